// File: rtl/mem_ctrl_pkg.sv
// Shared widths, constants, length encodings and FSM states for the memory controller.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTES  = WORD_W / 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [WORD_W-1:0] ZERO_WORD = '0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Byte count of a MEM access; any len with bit 1 set is a full word.
    function automatic logic [CNT_W-1:0] len_to_n(input logic [1:0] len);
        logic [CNT_W-1:0] n;
        if (len[1] == LEN_WORD[1])
            n = CNT_W'(BYTES);
        else if (len == LEN_HALF)
            n = CNT_W'(2);
        else
            n = CNT_W'(1);
        return n;
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: issue/receive counters, read-pending flag, and word lane assembly/extraction.
module mem_byte_seq
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic              issue,
    input  logic              is_read,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [CNT_W-1:0]  n_in,
    input  logic [WORD_W-1:0] wdata_in,
    input  logic [7:0]        ram_din,
    output logic [ADDR_W-1:0] issue_addr_c,
    output logic [7:0]        issue_byte_c,
    output logic              issue_left_c,
    output logic              last_issue_c,
    output logic              rd_done_c,
    output logic [WORD_W-1:0] word
);

    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  n;
    logic [WORD_W-1:0] wdata;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              rd_pend;

    assign issue_addr_c = base + ADDR_W'(issue_cnt);
    assign issue_byte_c = wdata[{issue_cnt[1:0], 3'b000} +: 8];
    assign issue_left_c = issue_cnt < n;
    assign last_issue_c = (issue_cnt + CNT_W'(1)) == n;
    // Done counts a capture landing this cycle so DONE follows the last byte directly.
    assign rd_done_c    = (recv_cnt == n) || (rd_pend && ((recv_cnt + CNT_W'(1)) == n));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            n         <= '0;
            wdata     <= ZERO_WORD;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            rd_pend   <= FALSE;
            word      <= ZERO_WORD;
        end else if (start) begin
            base      <= base_in;
            n         <= n_in;
            wdata     <= wdata_in;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            rd_pend   <= FALSE;
            word      <= ZERO_WORD;
        end else if (clear) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
            rd_pend   <= FALSE;
        end else begin
            if (issue)
                issue_cnt <= issue_cnt + CNT_W'(1);
            rd_pend <= issue && is_read;
            // Capture is independent of rdy so an issued byte is never dropped.
            if (rd_pend) begin
                word[{recv_cnt[1:0], 3'b000} +: 8] <= ram_din;
                recv_cnt <= recv_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// IF/MEM arbiter and byte-wide RAM bus controller (MEM has priority).
// Optional IO_STALL_EN adds io_buffer_full to hold stores to addresses with [17:16] == 2'b11.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
`ifdef IO_STALL_EN
    input  logic              io_buffer_full,
`endif
    input  logic              if_request,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [WORD_W-1:0] if_inst,
    output logic              if_enable,
    input  logic              mem_request,
    input  logic              mem_wr,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_enable,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              busy
);

    state_t            state, state_nxt;
    logic              owner_if, owner_if_nxt;
    logic [WORD_W-1:0] if_inst_nxt, mem_rdata_nxt;
    logic              if_enable_nxt, mem_enable_nxt;
    logic [7:0]        ram_dout_nxt;
    logic [ADDR_W-1:0] ram_a_nxt;
    logic              ram_wr_nxt;

    logic              seq_start, seq_clear, seq_issue, is_read_c, io_stall_c;
    logic [ADDR_W-1:0] base_sel_c, issue_addr_c;
    logic [CNT_W-1:0]  n_sel_c;
    logic [7:0]        issue_byte_c;
    logic              issue_left_c, last_issue_c, rd_done_c;
    logic [WORD_W-1:0] word;

    assign is_read_c  = (state == IF_RD) || (state == MEM_RD);
    assign base_sel_c = mem_request ? mem_addr : if_addr;
    assign n_sel_c    = mem_request ? len_to_n(mem_len) : CNT_W'(BYTES);

`ifdef IO_STALL_EN
    assign io_stall_c = (state == MEM_WR) && (issue_addr_c[17:16] == 2'b11) && io_buffer_full;
`else
    assign io_stall_c = FALSE;
`endif

    mem_byte_seq u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (seq_start),
        .clear        (seq_clear),
        .issue        (seq_issue),
        .is_read      (is_read_c),
        .base_in      (base_sel_c),
        .n_in         (n_sel_c),
        .wdata_in     (mem_wdata),
        .ram_din      (ram_din),
        .issue_addr_c (issue_addr_c),
        .issue_byte_c (issue_byte_c),
        .issue_left_c (issue_left_c),
        .last_issue_c (last_issue_c),
        .rd_done_c    (rd_done_c),
        .word         (word)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        owner_if_nxt   = owner_if;
        if_inst_nxt    = if_inst;
        mem_rdata_nxt  = mem_rdata;
        if_enable_nxt  = FALSE;
        mem_enable_nxt = FALSE;
        ram_dout_nxt   = ram_dout;
        ram_a_nxt      = ram_a;
        ram_wr_nxt     = FALSE;
        seq_start      = FALSE;
        seq_clear      = FALSE;
        seq_issue      = FALSE;

        if (rdy) begin
            case (state)
                IDLE: begin
                    if (mem_request) begin
                        seq_start    = TRUE;
                        owner_if_nxt = FALSE;
                        state_nxt    = mem_wr ? MEM_WR : MEM_RD;
                    end else if (if_request && !if_flush) begin
                        seq_start    = TRUE;
                        owner_if_nxt = TRUE;
                        state_nxt    = IF_RD;
                    end
                end
                IF_RD, MEM_RD: begin
                    if ((state == IF_RD) && if_flush) begin
                        seq_clear = TRUE;
                        state_nxt = IDLE;
                    end else begin
                        seq_issue = issue_left_c;
                        if (rd_done_c)
                            state_nxt = DONE;
                    end
                end
                MEM_WR: begin
                    if (issue_left_c && !io_stall_c) begin
                        seq_issue    = TRUE;
                        ram_wr_nxt   = TRUE;
                        ram_dout_nxt = issue_byte_c;
                        if (last_issue_c)
                            state_nxt = DONE;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    if (owner_if) begin
                        if (!if_flush) begin
                            if_enable_nxt = TRUE;
                            if_inst_nxt   = word;
                        end
                    end else begin
                        mem_enable_nxt = TRUE;
                        mem_rdata_nxt  = word;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (seq_issue)
            ram_a_nxt = issue_addr_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_if   <= FALSE;
            if_inst    <= ZERO_WORD;
            mem_rdata  <= ZERO_WORD;
            if_enable  <= FALSE;
            mem_enable <= FALSE;
            ram_dout   <= '0;
            ram_a      <= '0;
            ram_wr     <= FALSE;
            busy       <= FALSE;
        end else begin
            state      <= state_nxt;
            owner_if   <= owner_if_nxt;
            if_inst    <= if_inst_nxt;
            mem_rdata  <= mem_rdata_nxt;
            if_enable  <= if_enable_nxt;
            mem_enable <= mem_enable_nxt;
            ram_dout   <= ram_dout_nxt;
            ram_a      <= ram_a_nxt;
            ram_wr     <= ram_wr_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed spec scenarios plus randomized transactions
// checked against a transaction-level timing/data model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              rdy = 1'b1;
    logic              if_request = 1'b0;
    logic [31:0]       if_addr = '0;
    logic              if_flush = 1'b0;
    logic [31:0]       if_inst;
    logic              if_enable;
    logic              mem_request = 1'b0;
    logic              mem_wr = 1'b0;
    logic [1:0]        mem_len = 2'b00;
    logic [31:0]       mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic [31:0]       mem_rdata;
    logic              mem_enable;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [31:0]       ram_a;
    logic              ram_wr;
    logic              busy;
`ifdef IO_STALL_EN
    logic              io_buffer_full = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
`ifdef IO_STALL_EN
        .io_buffer_full (io_buffer_full),
`endif
        .if_request  (if_request),
        .if_addr     (if_addr),
        .if_flush    (if_flush),
        .if_inst     (if_inst),
        .if_enable   (if_enable),
        .mem_request (mem_request),
        .mem_wr      (mem_wr),
        .mem_len     (mem_len),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_enable  (mem_enable),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .ram_a       (ram_a),
        .ram_wr      (ram_wr),
        .busy        (busy)
    );

    // RAM contents: a few fixed bytes from the test plan, a hash elsewhere.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h13;
            32'h0000_1001: return 8'h05;
            32'h0000_1002: return 8'h00;
            32'h0000_1003: return 8'h00;
            32'h0000_2000: return 8'hEF;
            32'h0000_2001: return 8'hBE;
            32'h0000_2002: return 8'hAD;
            32'h0000_2003: return 8'hDE;
            32'hFFFF_FFFF: return 8'h80;
            default:       return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
        endcase
    endfunction

    assign ram_din = ram_byte(ram_a);

    function automatic logic [31:0] model_word(input logic [31:0] base, input int n);
        logic [31:0] w = '0;
        for (int k = 0; k < n; k++)
            w = w | (32'(ram_byte(base + 32'(k))) << (8 * k));
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction with rdy held high: reads complete at T+N+2, writes at T+N+1.
    task automatic run_txn(input bit is_if, input bit wr, input int n,
                           input logic [31:0] addr, input logic [31:0] wd);
        int          lat;
        logic [31:0] exp_word;
        lat      = wr ? n + 1 : n + 2;
        exp_word = model_word(addr, n);
        @(negedge clk);
        if (is_if) begin
            if_request = 1'b1;
            if_addr    = addr;
        end else begin
            mem_request = 1'b1;
            mem_wr      = wr;
            mem_len     = (n == 1) ? 2'b00 : (n == 2) ? 2'b01 : {1'b1, 1'($urandom)};
            mem_addr    = addr;
            mem_wdata   = wd;
        end
        @(posedge clk); #1;
        for (int c = 1; c <= lat + 1; c++) begin
            @(posedge clk); #1;
            if (c <= n) begin
                check("ram_a", ram_a, addr + 32'(c - 1));
                check("ram_wr", 32'(ram_wr), 32'(wr));
                if (wr)
                    check("ram_dout", 32'(ram_dout), (wd >> (8 * (c - 1))) & 32'hFF);
            end else begin
                check("ram_wr_idle", 32'(ram_wr), 32'd0);
            end
            check("busy", 32'(busy), 32'(c < lat));
            if (is_if) begin
                check("if_enable", 32'(if_enable), 32'(c == lat));
                check("mem_enable_quiet", 32'(mem_enable), 32'd0);
            end else begin
                check("mem_enable", 32'(mem_enable), 32'(c == lat));
                check("if_enable_quiet", 32'(if_enable), 32'd0);
            end
            if (c == lat) begin
                if (is_if)
                    check("if_inst", if_inst, exp_word);
                else if (!wr)
                    check("mem_rdata", mem_rdata, exp_word);
                if_request  = 1'b0;
                mem_request = 1'b0;
            end
        end
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #20;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_if_enable", 32'(if_enable), 32'd0);
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed scenarios from the test plan.
        run_txn(1'b1, 1'b0, 4, 32'h0000_1000, 32'h0);
        check("fetch_word", if_inst, 32'h0000_0513);
        run_txn(1'b0, 1'b1, 2, 32'h0000_2002, 32'h0000_BEEF);
        run_txn(1'b0, 1'b0, 1, 32'hFFFF_FFFF, 32'h0);
        check("load_byte_top", mem_rdata, 32'h0000_0080);
        run_txn(1'b0, 1'b0, 4, 32'hFFFF_FFFF, 32'h0);
        run_txn(1'b0, 1'b0, 2, 32'hFFFF_FFFF, 32'h0);

        // Simultaneous requests: MEM first, IF granted after MEM's DONE.
        @(negedge clk);
        if_request  = 1'b1; if_addr  = 32'h0000_1000;
        mem_request = 1'b1; mem_wr   = 1'b0; mem_len = 2'b10; mem_addr = 32'h0000_2000;
        @(posedge clk); #1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            check("arb_mem_enable", 32'(mem_enable), 32'(c == 6));
            check("arb_if_enable", 32'(if_enable), 32'(c == 13));
            if (c == 6) begin
                check("arb_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
                mem_request = 1'b0;
            end
            if (c == 7) check("arb_no_if_issue", ram_a, 32'h0000_2003);
            if (c == 8) check("arb_if_issue", ram_a, 32'h0000_1000);
            if (c == 13) begin
                check("arb_if_inst", if_inst, 32'h0000_0513);
                if_request = 1'b0;
            end
        end

        // Flush mid-fetch.
        @(negedge clk);
        if_request = 1'b1; if_addr = 32'h0000_3000;
        @(posedge clk); #1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            check("flush_if_enable", 32'(if_enable), 32'd0);
            check("flush_ram_wr", 32'(ram_wr), 32'd0);
            if (c == 3) begin
                if_flush   = 1'b1;
                if_request = 1'b0;
            end
            if (c == 4) begin
                check("flush_busy", 32'(busy), 32'd0);
                check("flush_ram_a", ram_a, 32'h0000_3002);
                if_flush = 1'b0;
            end
        end
        run_txn(1'b1, 1'b0, 4, 32'h0000_3000, 32'h0);

        // rdy low at edges T+2..T+4 of a fetch.
        @(negedge clk);
        if_request = 1'b1; if_addr = 32'h0000_1000;
        @(posedge clk); #1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c >= 1 && c <= 4) check("stall_ram_a_hold", ram_a, 32'h0000_1000);
            if (c == 5) check("stall_ram_a_resume", ram_a, 32'h0000_1001);
            check("stall_busy", 32'(busy), 32'(c < 9));
            check("stall_if_enable", 32'(if_enable), 32'(c == 9));
            if (c == 1) rdy = 1'b0;
            if (c == 4) rdy = 1'b1;
            if (c == 9) begin
                check("stall_if_inst", if_inst, 32'h0000_0513);
                if_request = 1'b0;
            end
        end

        // Asynchronous reset mid-fetch.
        @(negedge clk);
        if_request = 1'b1; if_addr = 32'h0000_4000;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ram_a", ram_a, 32'd0);
        check("arst_if_inst", if_inst, 32'd0);
        check("arst_mem_rdata", mem_rdata, 32'd0);
        if_request = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("arst_no_enable", 32'(if_enable | mem_enable), 32'd0);
        end

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            int          kind, n;
            logic [31:0] addr;
            kind = int'($urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0:       n = 1;
                1:       n = 2;
                default: n = 4;
            endcase
            if (kind == 0) n = 4;
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            run_txn(kind == 0, kind == 2, n, addr, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
